mseq_lc_ctrl: RTL and testbench
===============================

Name: mseq_lc_ctrl

Overview:
- Microsequencer for the 2048x22 LSI-11 MicROM, which has a one-cycle registered read.
- Generates the next location counter (pin_lc) every cycle from a decoded next-address command, branch condition, microsubroutine stack and external translate address.
- Tracks which address the word currently on the microinstruction bus came from.
- Sits between the microword decoder and the MicROM; it is the sole driver of the MicROM address.

Parameters:
- RESET_VECTOR, 11'h000: microaddress fetched on and after reset.
- RSTACK_DEPTH, 4: return-stack entries (1..8).
- BKPT_ADDR, 11'h7FF: breakpoint address (used only with the optional feature).

Ports:
- pin_clk  in  1  main clock.
- pin_rst_n  in  1  synchronous reset, active low.
- pin_op  in  3  next-address command for the current word: 0 NEXT, 1 JUMP, 2 BRANCH, 3 CALL, 4 RETURN, 5 TRANS, 6/7 HOLD.
- pin_cond  in  1  branch condition for BRANCH.
- pin_addr  in  11  jump/branch/call target.
- pin_taddr  in  11  translate (opcode dispatch) target.
- pin_stall  in  1  freeze the sequencer and re-read the current word.
- pin_lc  out  11  MicROM address (combinational next address).
- pin_cur  out  11  address of the word now on the MicROM output.
- pin_mvalid  out  1  MicROM output is valid and is being executed.
- pin_sp  out  4  return-stack occupancy.
- pin_ovf  out  1  sticky stack overflow.
- pin_unf  out  1  sticky stack underflow.
- pin_halt  out  1  breakpoint halt (0 when the optional feature is compiled out).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - cur=RESET_VECTOR, mvalid=0, sp=0, ovf=0, unf=0, halt=0, stack contents don't-care.
  - pin_lc=RESET_VECTOR combinationally while rst_n=0.
  - Reset mid-CALL or mid-stall discards all pending state.
- States:
  - BUBBLE (mvalid=0): pin_lc=cur and ops are ignored. The next edge goes to RUN with mvalid=1 and cur unchanged. This gives exactly one bubble after reset, so the first executed word is rom[RESET_VECTOR].
  - RUN (mvalid=1, stall=0): pin_lc = f(op); cur <= pin_lc at the edge. pin_mo in the next cycle is rom[cur].
  - STALL (mvalid=1, stall=1): pin_lc=cur, so the ROM re-reads the same word. No stack or flag change and op is ignored. The next cycle resumes with the same word.
  - HALT (optional feature only): behaves as STALL until reset.
- Next address in RUN:
  - NEXT: cur+1, 11-bit wrap (7FF→000).
  - JUMP: pin_addr.
  - BRANCH: pin_cond ? pin_addr : cur+1.
  - TRANS: pin_taddr.
  - HOLD: cur.
  - CALL: push cur+1, then pin_addr. If sp==RSTACK_DEPTH, set ovf, do not push and leave sp unchanged, but the jump still happens.
  - RETURN: pop (sp-1) into pin_lc. If sp==0, set unf and pin_lc=RESET_VECTOR.
- Stack is LIFO; entries above sp are don't-care.
- ovf and unf clear only on reset.
- pin_cur, pin_sp and the flags are registered; pin_lc is combinational from the registers and inputs.
- Stall has priority over every op and over the breakpoint.

Optional Feature:
- Macro LSI11_MSEQ_BREAK_EN.
- Defined: when in RUN without stall and the computed pin_lc==BKPT_ADDR, the sequencer commits cur<=BKPT_ADDR and sets halt=1 at that edge. From the following cycle it behaves as STALL (pin_lc=cur) until reset. The breakpoint word is fetched but not advanced past.
- Undefined: no comparator, pin_halt tied 0, HALT state absent.

Test Plan:
- Reset release with RESET_VECTOR=0: pin_lc=000 during reset and the bubble cycle. mvalid rises one cycle after release. With op=NEXT the lc sequence is 001, 002, 003 and pin_cur lags pin_lc by one cycle.
- Wrap and branch:
  - cur=7FF with NEXT → pin_lc=000.
  - BRANCH addr=156, cond=1 → 156.
  - BRANCH cond=0 at cur=022 → 023.
- Nested CALL/RETURN:
  - At cur=010, CALL 100 → lc=100, sp=1.
  - At cur=100, CALL 200 → sp=2.
  - RETURN → 101.
  - RETURN → 011, sp=0, ovf=unf=0.
- Stack bounds with depth 4:
  - Five CALLs → ovf=1, sp=4, fifth jump taken.
  - Five RETURNs → fifth gives lc=RESET_VECTOR and unf=1.
  - Flags stay set until reset.
- Stall on CALL at cur=020: pin_lc=020 for 3 cycles, sp unchanged. After release, CALL executes once: sp=1, return entry 021.
- With LSI11_MSEQ_BREAK_EN and BKPT_ADDR=116: JUMP 116 → halt=1 next cycle and pin_lc holds at 116 regardless of op. Reset clears halt.

Source files
------------

// File: rtl/mseq_lc_ctrl.sv
// mseq_lc_ctrl: microsequencer for the 2048x22 LSI-11 MicROM.
//
// The MicROM has a one-cycle registered read, so pin_lc is the address that
// will be read at the next rising edge and pin_cur names the word currently
// on the MicROM output. This block is the only driver of the MicROM address.
//
// Optional feature: define LSI11_MSEQ_BREAK_EN to add a breakpoint comparator
// against BKPT_ADDR. Without it pin_halt is tied low and there is no halt state.
//
// Ports:
//   pin_clk     in   main clock
//   pin_rst_n   in   synchronous reset, active low
//   pin_op      in   next-address command (NEXT/JUMP/BRANCH/CALL/RETURN/TRANS/HOLD)
//   pin_cond    in   branch condition used by BRANCH
//   pin_addr    in   jump/branch/call target
//   pin_taddr   in   translate (opcode dispatch) target
//   pin_stall   in   freeze the sequencer and re-read the current word
//   pin_lc      out  MicROM address (combinational next address)
//   pin_cur     out  address of the word now on the MicROM output
//   pin_mvalid  out  MicROM output is valid and being executed
//   pin_sp      out  return-stack occupancy
//   pin_ovf     out  sticky stack overflow
//   pin_unf     out  sticky stack underflow
//   pin_halt    out  breakpoint halt
module mseq_lc_ctrl #(
   parameter logic [10:0] RESET_VECTOR = 11'h000,
   parameter int unsigned RSTACK_DEPTH = 4,
   parameter logic [10:0] BKPT_ADDR    = 11'h7FF
) (
   input  logic        pin_clk,
   input  logic        pin_rst_n,
   input  logic [2:0]  pin_op,
   input  logic        pin_cond,
   input  logic [10:0] pin_addr,
   input  logic [10:0] pin_taddr,
   input  logic        pin_stall,
   output logic [10:0] pin_lc,
   output logic [10:0] pin_cur,
   output logic        pin_mvalid,
   output logic [3:0]  pin_sp,
   output logic        pin_ovf,
   output logic        pin_unf,
   output logic        pin_halt
);

   // Storage is always sized for the largest legal depth; only the first
   // RSTACK_DEPTH slots are ever written.
   localparam int unsigned StackSlots = 8;
   localparam logic [3:0]  DepthLim   = 4'(RSTACK_DEPTH);

   localparam logic [2:0] OpNext   = 3'd0;
   localparam logic [2:0] OpJump   = 3'd1;
   localparam logic [2:0] OpBranch = 3'd2;
   localparam logic [2:0] OpCall   = 3'd3;
   localparam logic [2:0] OpReturn = 3'd4;
   localparam logic [2:0] OpTrans  = 3'd5;

`ifdef LSI11_MSEQ_BREAK_EN
   typedef enum logic [1:0] {StBubble, StRun, StHalt} state_e;
`else
   typedef enum logic [0:0] {StBubble, StRun} state_e;
`endif

   state_e      state_q, state_d;
   logic [10:0] cur_q, cur_d;
   logic [3:0]  sp_q, sp_d;
   logic        ovf_q, ovf_d;
   logic        unf_q, unf_d;
   logic [10:0] stack_q [StackSlots];
   logic [10:0] stack_d [StackSlots];

   logic [10:0] seq_incr;
   logic [2:0]  push_idx;
   logic [2:0]  pop_idx;
   logic [10:0] lc;

   assign seq_incr = cur_q + 11'd1;
   assign push_idx = sp_q[2:0];
   assign pop_idx  = 3'(sp_q - 4'd1);

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      sp_d    = sp_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      stack_d = stack_q;
      lc      = cur_q;

      case (state_q)
         // One bubble after reset while the first word is read out of the ROM.
         StBubble: state_d = StRun;
         StRun: begin
            // Stall keeps lc at cur so the ROM re-reads the same word.
            if (!pin_stall) begin
               case (pin_op)
                  OpNext:   lc = seq_incr;
                  OpJump:   lc = pin_addr;
                  OpBranch: lc = pin_cond ? pin_addr : seq_incr;
                  OpTrans:  lc = pin_taddr;
                  OpCall: begin
                     lc = pin_addr;
                     // A full stack drops the return address but still jumps.
                     if (sp_q >= DepthLim) begin
                        ovf_d = 1'b1;
                     end else begin
                        stack_d[push_idx] = seq_incr;
                        sp_d              = sp_q + 4'd1;
                     end
                  end
                  OpReturn: begin
                     if (sp_q == 4'd0) begin
                        unf_d = 1'b1;
                        lc    = RESET_VECTOR;
                     end else begin
                        lc   = stack_q[pop_idx];
                        sp_d = sp_q - 4'd1;
                     end
                  end
                  default:  lc = cur_q;
               endcase
               cur_d = lc;
`ifdef LSI11_MSEQ_BREAK_EN
               // The breakpoint word is fetched, then the sequencer freezes on it.
               if (lc == BKPT_ADDR) begin
                  state_d = StHalt;
               end
`endif
            end
         end
         default: ;
      endcase

      if (!pin_rst_n) begin
         lc = RESET_VECTOR;
      end
   end

   always_ff @(posedge pin_clk) begin
      if (!pin_rst_n) begin
         state_q <= StBubble;
         cur_q   <= RESET_VECTOR;
         sp_q    <= 4'd0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         sp_q    <= sp_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Stack contents are meaningless after reset, so they carry no reset.
   always_ff @(posedge pin_clk) begin
      stack_q <= stack_d;
   end

   assign pin_lc     = lc;
   assign pin_cur    = cur_q;
   assign pin_mvalid = (state_q != StBubble);
   assign pin_sp     = sp_q;
   assign pin_ovf    = ovf_q;
   assign pin_unf    = unf_q;

`ifdef LSI11_MSEQ_BREAK_EN
   assign pin_halt = (state_q == StHalt);
`else
   logic unused_bkpt;
   assign unused_bkpt = ^BKPT_ADDR;
   assign pin_halt    = 1'b0;
`endif

endmodule

// File: tb/tb_mseq_lc_ctrl.sv
// Self-checking bench for mseq_lc_ctrl: a directed vector table, a breakpoint
// sequence (LSI11_MSEQ_BREAK_EN builds only) and a randomized run against a
// queue-based reference model.
module tb_mseq_lc_ctrl;

   localparam logic [10:0] RV    = 11'h000;
   localparam int          DEPTH = 4;
   localparam logic [10:0] BKPT  = 11'h116;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  op;
   logic        cond;
   logic [10:0] addr;
   logic [10:0] taddr;
   logic        stall;
   logic [10:0] lc;
   logic [10:0] cur;
   logic        mvalid;
   logic [3:0]  sp;
   logic        ovf;
   logic        unf;
   logic        halt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mseq_lc_ctrl #(
      .RESET_VECTOR (RV),
      .RSTACK_DEPTH (DEPTH),
      .BKPT_ADDR    (BKPT)
   ) dut (
      .pin_clk    (clk),
      .pin_rst_n  (rst_n),
      .pin_op     (op),
      .pin_cond   (cond),
      .pin_addr   (addr),
      .pin_taddr  (taddr),
      .pin_stall  (stall),
      .pin_lc     (lc),
      .pin_cur    (cur),
      .pin_mvalid (mvalid),
      .pin_sp     (sp),
      .pin_ovf    (ovf),
      .pin_unf    (unf),
      .pin_halt   (halt)
   );

   task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [2:0] o, input logic c,
                        input logic [10:0] a, input logic [10:0] t, input logic s);
      rst_n = r;
      op    = o;
      cond  = c;
      addr  = a;
      taddr = t;
      stall = s;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rst_n;
      logic [2:0]  op;
      logic        cond;
      logic [10:0] addr;
      logic [10:0] taddr;
      logic        stall;
      logic [10:0] e_lc;
      logic [10:0] e_cur;
      logic        e_mv;
      logic [3:0]  e_sp;
      logic        e_ovf;
      logic        e_unf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic r, logic [2:0] o, logic c, logic [10:0] a,
                               logic [10:0] t, logic s, logic [10:0] elc,
                               logic [10:0] ecur, logic emv, logic [3:0] esp,
                               logic eovf, logic eunf);
      vec_t v;
      v.rst_n = r; v.op = o; v.cond = c; v.addr = a; v.taddr = t; v.stall = s;
      v.e_lc = elc; v.e_cur = ecur; v.e_mv = emv; v.e_sp = esp;
      v.e_ovf = eovf; v.e_unf = eunf;
      return v;
   endfunction

   // ---------------- reference model ----------------
   logic [10:0] m_cur;
   logic        m_mv;
   logic        m_ovf;
   logic        m_unf;
   logic        m_halt;
   logic [10:0] m_stack[$];

   function automatic logic [10:0] model_lc();
      if (!rst_n) return RV;
      if (!m_mv || stall || m_halt) return m_cur;
      case (op)
         3'd0: return m_cur + 11'd1;
         3'd1: return addr;
         3'd2: return cond ? addr : m_cur + 11'd1;
         3'd3: return addr;
         3'd4: return (m_stack.size() == 0) ? RV : m_stack[$];
         3'd5: return taddr;
         default: return m_cur;
      endcase
   endfunction

   task automatic model_edge(input logic [10:0] nxt);
      if (!rst_n) begin
         m_cur = RV; m_mv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_halt = 1'b0;
         m_stack.delete();
      end else if (!m_mv) begin
         m_mv = 1'b1;
      end else if (!stall && !m_halt) begin
         if (op == 3'd3) begin
            if (m_stack.size() == DEPTH) m_ovf = 1'b1;
            else m_stack.push_back(m_cur + 11'd1);
         end else if (op == 3'd4) begin
            if (m_stack.size() == 0) m_unf = 1'b1;
            else void'(m_stack.pop_back());
         end
         m_cur = nxt;
`ifdef LSI11_MSEQ_BREAK_EN
         if (nxt == BKPT) m_halt = 1'b1;
`endif
      end
   endtask

   initial begin
      logic [10:0] exp_lc;
      string       tag;

      // NEXT=0 JUMP=1 BRANCH=2 CALL=3 RETURN=4 TRANS=5 HOLD=6/7
      //             rst op  c  addr    taddr  st  lc      cur    mv sp ovf unf
      tbl.push_back(mk(0, 0, 0, 11'h000, 11'h000, 0, 11'h000, 11'h000, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 11'h000, 11'h000, 0, 11'h000, 11'h000, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 11'h000, 11'h000, 0, 11'h001, 11'h000, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 11'h000, 11'h000, 0, 11'h002, 11'h001, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 11'h000, 11'h000, 0, 11'h003, 11'h002, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 11'h7FF, 11'h000, 0, 11'h7FF, 11'h003, 1, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 11'h000, 11'h000, 0, 11'h000, 11'h7FF, 1, 0, 0, 0));
      tbl.push_back(mk(1, 2, 1, 11'h156, 11'h000, 0, 11'h156, 11'h000, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 11'h022, 11'h000, 0, 11'h022, 11'h156, 1, 0, 0, 0));
      tbl.push_back(mk(1, 2, 0, 11'h3AB, 11'h000, 0, 11'h023, 11'h022, 1, 0, 0, 0));
      tbl.push_back(mk(1, 5, 0, 11'h000, 11'h2C5, 0, 11'h2C5, 11'h023, 1, 0, 0, 0));
      tbl.push_back(mk(1, 6, 0, 11'h3AB, 11'h000, 0, 11'h2C5, 11'h2C5, 1, 0, 0, 0));
      tbl.push_back(mk(1, 7, 1, 11'h3AB, 11'h000, 0, 11'h2C5, 11'h2C5, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 11'h010, 11'h000, 0, 11'h010, 11'h2C5, 1, 0, 0, 0));
      tbl.push_back(mk(1, 3, 0, 11'h100, 11'h000, 0, 11'h100, 11'h010, 1, 0, 0, 0));
      tbl.push_back(mk(1, 3, 0, 11'h200, 11'h000, 0, 11'h200, 11'h100, 1, 1, 0, 0));
      tbl.push_back(mk(1, 4, 0, 11'h000, 11'h000, 0, 11'h101, 11'h200, 1, 2, 0, 0));
      tbl.push_back(mk(1, 4, 0, 11'h000, 11'h000, 0, 11'h011, 11'h101, 1, 1, 0, 0));
      tbl.push_back(mk(1, 0, 0, 11'h000, 11'h000, 0, 11'h012, 11'h011, 1, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 11'h020, 11'h000, 0, 11'h020, 11'h012, 1, 0, 0, 0));
      tbl.push_back(mk(1, 3, 0, 11'h300, 11'h000, 1, 11'h020, 11'h020, 1, 0, 0, 0));
      tbl.push_back(mk(1, 3, 0, 11'h300, 11'h000, 1, 11'h020, 11'h020, 1, 0, 0, 0));
      tbl.push_back(mk(1, 3, 0, 11'h300, 11'h000, 1, 11'h020, 11'h020, 1, 0, 0, 0));
      tbl.push_back(mk(1, 3, 0, 11'h300, 11'h000, 0, 11'h300, 11'h020, 1, 0, 0, 0));
      tbl.push_back(mk(1, 4, 0, 11'h000, 11'h000, 0, 11'h021, 11'h300, 1, 1, 0, 0));
      tbl.push_back(mk(1, 3, 0, 11'h040, 11'h000, 0, 11'h040, 11'h021, 1, 0, 0, 0));
      tbl.push_back(mk(1, 3, 0, 11'h050, 11'h000, 0, 11'h050, 11'h040, 1, 1, 0, 0));
      tbl.push_back(mk(1, 3, 0, 11'h060, 11'h000, 0, 11'h060, 11'h050, 1, 2, 0, 0));
      tbl.push_back(mk(1, 3, 0, 11'h070, 11'h000, 0, 11'h070, 11'h060, 1, 3, 0, 0));
      tbl.push_back(mk(1, 3, 0, 11'h080, 11'h000, 0, 11'h080, 11'h070, 1, 4, 0, 0));
      tbl.push_back(mk(1, 4, 0, 11'h000, 11'h000, 0, 11'h061, 11'h080, 1, 4, 1, 0));
      tbl.push_back(mk(1, 4, 0, 11'h000, 11'h000, 0, 11'h051, 11'h061, 1, 3, 1, 0));
      tbl.push_back(mk(1, 4, 0, 11'h000, 11'h000, 0, 11'h041, 11'h051, 1, 2, 1, 0));
      tbl.push_back(mk(1, 4, 0, 11'h000, 11'h000, 0, 11'h022, 11'h041, 1, 1, 1, 0));
      tbl.push_back(mk(1, 4, 0, 11'h000, 11'h000, 0, 11'h000, 11'h022, 1, 0, 1, 0));
      tbl.push_back(mk(1, 0, 0, 11'h000, 11'h000, 0, 11'h001, 11'h000, 1, 0, 1, 1));
      tbl.push_back(mk(0, 3, 0, 11'h155, 11'h000, 1, 11'h000, 11'h001, 1, 0, 1, 1));
      tbl.push_back(mk(1, 0, 0, 11'h000, 11'h000, 0, 11'h000, 11'h000, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 11'h000, 11'h000, 0, 11'h001, 11'h000, 1, 0, 0, 0));

      drive(1'b0, 3'd0, 1'b0, 11'h000, 11'h000, 1'b0);
      repeat (2) @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         drive(tbl[i].rst_n, tbl[i].op, tbl[i].cond, tbl[i].addr, tbl[i].taddr, tbl[i].stall);
         @(negedge clk);
         tag = $sformatf("row%0d", i);
         chk({tag, ".lc"},  lc,              tbl[i].e_lc);
         chk({tag, ".cur"}, cur,             tbl[i].e_cur);
         chk({tag, ".mv"},  11'(mvalid),     11'(tbl[i].e_mv));
         chk({tag, ".sp"},  11'(sp),         11'(tbl[i].e_sp));
         chk({tag, ".ovf"}, 11'(ovf),        11'(tbl[i].e_ovf));
         chk({tag, ".unf"}, 11'(unf),        11'(tbl[i].e_unf));
         chk({tag, ".halt"}, 11'(halt),      11'h000);
         @(posedge clk);
         #1;
      end

`ifdef LSI11_MSEQ_BREAK_EN
      // cur=001 here. Jump onto the breakpoint, then try to move off it.
      drive(1'b1, 3'd1, 1'b0, BKPT, 11'h000, 1'b0);
      @(negedge clk);
      chk("bk.lc_jump", lc, BKPT);
      chk("bk.halt_pre", 11'(halt), 11'h000);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 3'(k + 1), 1'b1, 11'h2AA, 11'h155, 1'b0);
         @(negedge clk);
         chk($sformatf("bk.halt%0d", k), 11'(halt), 11'h001);
         chk($sformatf("bk.lc%0d", k), lc, BKPT);
         chk($sformatf("bk.cur%0d", k), cur, BKPT);
         @(posedge clk);
         #1;
      end
      drive(1'b0, 3'd0, 1'b0, 11'h000, 11'h000, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b1, 3'd0, 1'b0, 11'h000, 11'h000, 1'b0);
      @(negedge clk);
      chk("bk.halt_rst", 11'(halt), 11'h000);
      @(posedge clk);
      #1;
`endif

      // Randomized run against the model, starting from a fresh reset.
      drive(1'b0, 3'd0, 1'b0, 11'h000, 11'h000, 1'b0);
      @(posedge clk);
      model_edge(RV);
      #1;
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom_range(0, 99) != 0), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)),
               11'($urandom_range(0, 2047)), ($urandom_range(0, 7) == 0));
         // Bias returns/calls so the stack hits both bounds often.
         if ($urandom_range(0, 3) == 0) op = ($urandom_range(0, 1) != 0) ? 3'd3 : 3'd4;
         @(negedge clk);
         exp_lc = model_lc();
         tag = $sformatf("rnd%0d", n);
         chk({tag, ".lc"},  lc,          exp_lc);
         chk({tag, ".cur"}, cur,         m_cur);
         chk({tag, ".mv"},  11'(mvalid), 11'(m_mv));
         chk({tag, ".sp"},  11'(sp),     11'(m_stack.size()));
         chk({tag, ".ovf"}, 11'(ovf),    11'(m_ovf));
         chk({tag, ".unf"}, 11'(unf),    11'(m_unf));
         chk({tag, ".halt"}, 11'(halt),  11'(m_halt));
         @(posedge clk);
         model_edge(exp_lc);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
